// File: rtl/simple_pkg.sv
// Shared definitions for the SIMPLE core: default widths, fetch FSM
// state encoding and opcode field constants used for HLT detection.
package simple_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 16;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_DROP  = 3'd2,
      ST_VALID = 3'd3,
      ST_HALT  = 3'd4
   } fetch_state_t;

   localparam logic [1:0] OP_ARITH = 2'b11;
   localparam logic [3:0] FN_HLT   = 4'b1111;

   // HLT is an arithmetic-class opcode with the all-ones function field.
   function automatic logic is_hlt(input logic [15:0] word);
      return (word[15:14] == OP_ARITH) && (word[7:4] == FN_HLT);
   endfunction

endpackage

// File: rtl/fetch_pc.sv
// Program counter register: reset value, redirect load and post-fetch
// increment (wraps modulo 2^ADDR_W). Load has priority over increment.
module fetch_pc #(
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              inc,
   input  logic [ADDR_W-1:0] target,
   output logic [ADDR_W-1:0] pc
);

   // PC update: redirect beats sequential advance, otherwise hold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc <= RESET_PC;
      end else if (load) begin
         pc <= target;
      end else if (inc) begin
         pc <= pc + 1'b1;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage of the SIMPLE core. Issues single-word requests
// to instruction memory (req/ack), registers the returned word as
// `command` for decode (valid/ready) and accepts PC redirects.
// Optional HLT detection is enabled by defining HALT_DETECT_EN.
module fetch_unit
   import simple_pkg::*;
#(
   parameter int                ADDR_W   = ADDR_W_DEF,
   parameter int                DATA_W   = DATA_W_DEF,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic [DATA_W-1:0] command,
   output logic              command_valid,
   input  logic              command_ready,
   output logic [ADDR_W-1:0] pc_out,
   input  logic              pc_load,
   input  logic [ADDR_W-1:0] pc_target,
   output logic              halted
);

   fetch_state_t      state;
   fetch_state_t      state_next;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] drop_addr;
   logic              capture;
   logic              hold_addr;

   // Every pc_load redirects the PC; a capture advances it by one.
   fetch_pc #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk    (clk),
      .rst    (rst),
      .load   (pc_load),
      .inc    (capture),
      .target (pc_target),
      .pc     (pc)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: redirect has priority, outstanding requests always complete.
   always_comb begin
      state_next = state;
      capture    = 1'b0;
      hold_addr  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (run) begin
               state_next = ST_REQ;
            end
         end
         ST_REQ: begin
            if (pc_load) begin
               // Redirect with ack retires the old request and reissues
               // at once; without ack the old request must still finish.
               if (!imem_ack) begin
                  state_next = ST_DROP;
                  hold_addr  = 1'b1;
               end
            end else if (imem_ack) begin
               capture    = 1'b1;
               state_next = ST_VALID;
            end
         end
         ST_DROP: begin
            if (imem_ack) begin
               state_next = ST_REQ;
            end
         end
         ST_VALID: begin
            if (pc_load) begin
               state_next = ST_REQ;
            end else if (command_ready) begin
`ifdef HALT_DETECT_EN
               if (is_hlt(command[15:0])) begin
                  state_next = ST_HALT;
               end else begin
                  state_next = run ? ST_REQ : ST_IDLE;
               end
`else
               state_next = run ? ST_REQ : ST_IDLE;
`endif
            end
         end
`ifdef HALT_DETECT_EN
         ST_HALT: begin
            if (pc_load) begin
               state_next = ST_REQ;
            end
         end
`endif
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Address of a request being drained after a redirect, and the instruction register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_addr <= '0;
         command   <= '0;
         pc_out    <= '0;
      end else begin
         if (hold_addr) begin
            drop_addr <= pc;
         end
         if (capture) begin
            command <= imem_rdata;
            pc_out  <= pc;
         end
      end
   end

   // Memory request outputs are state-decoded so they cannot move mid-transaction.
   always_comb begin
      imem_req  = 1'b0;
      imem_addr = '0;
      case (state)
         ST_REQ: begin
            imem_req  = 1'b1;
            imem_addr = pc;
         end
         ST_DROP: begin
            imem_req  = 1'b1;
            imem_addr = drop_addr;
         end
         default: begin
            imem_req  = 1'b0;
            imem_addr = '0;
         end
      endcase
   end

   assign command_valid = (state == ST_VALID);

`ifdef HALT_DETECT_EN
   assign halted = (state == ST_HALT);
`else
   assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized
// latency/stall/redirect phase checked against a PC-stream model.
module tb_fetch_unit;

   localparam int AW = 16;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst, run, imem_req, imem_ack, command_valid, command_ready;
   logic          pc_load, halted;
   logic [AW-1:0] imem_addr, pc_out, pc_target;
   logic [DW-1:0] imem_rdata, command;

   logic          run2, imem_req2, ack2, command_valid2, ready2, halted2;
   logic [AW-1:0] addr2, pc_out2;
   logic [DW-1:0] rdata2, command2;

   logic [15:0]   mem [0:255];
   int            lat;
   int            cnt = 0;
   int            cyc = 0;
   int            tests = 0;
   int            fails = 0;
   logic [AW-1:0] exp_pc, tgt;
   int            stall, last;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fetch_unit dut (
      .clk(clk), .rst(rst), .run(run),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .command(command), .command_valid(command_valid),
      .command_ready(command_ready), .pc_out(pc_out),
      .pc_load(pc_load), .pc_target(pc_target), .halted(halted)
   );

   assign ack2   = imem_req2;
   assign rdata2 = 16'h1234;

   fetch_unit #(.RESET_PC(16'hFFFF)) dut2 (
      .clk(clk), .rst(rst), .run(run2),
      .imem_req(imem_req2), .imem_addr(addr2),
      .imem_ack(ack2), .imem_rdata(rdata2),
      .command(command2), .command_valid(command_valid2),
      .command_ready(ready2), .pc_out(pc_out2),
      .pc_load(1'b0), .pc_target(16'h0000), .halted(halted2)
   );

   // Memory responder: ack on the lat-th cycle of a request, data from mem.
   always @(negedge clk) begin
      if (rst || !imem_req) begin
         imem_ack <= 1'b0;
         cnt = 0;
      end else begin
         cnt = cnt + 1;
         if (cnt >= lat) begin
            imem_ack   <= 1'b1;
            imem_rdata <= mem[imem_addr[7:0]];
            cnt = 0;
         end else begin
            imem_ack <= 1'b0;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!command_valid && n < 30);
      check({tag, "_valid"}, {31'b0, command_valid}, 1);
   endtask

   task automatic check_cmd(input string tag);
      check({tag, "_cmd"}, command, mem[exp_pc[7:0]]);
      check({tag, "_pc"}, pc_out, exp_pc);
   endtask

   initial begin
      rst = 1'b1; run = 1'b0; pc_load = 1'b0; pc_target = '0;
      command_ready = 1'b0; lat = 1; run2 = 1'b0; ready2 = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom) & 16'h7FFF;
      mem[0] = 16'hCF0F; mem[1] = 16'hCF20; mem[2] = 16'h3D00;
      mem[8'h80] = 16'hC0F0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_req", imem_req, 0);
      check("rst_addr", imem_addr, 0);
      check("rst_cmd", command, 0);
      check("rst_valid", command_valid, 0);
      check("rst_pcout", pc_out, 0);
      check("rst_halted", halted, 0);
      check("rst_addr2", addr2, 0);

      // In-order stream, one instruction every two cycles
      rst = 1'b0; run = 1'b1; command_ready = 1'b1; exp_pc = 0;
      for (int i = 0; i < 3; i++) begin
         wait_valid("seq");
         check_cmd("seq");
         if (i > 0) check("seq_gap", cyc - last, 2);
         last = cyc;
         if (i < 2) exp_pc = exp_pc + 1;
         else command_ready = 1'b0;
      end

      // Decode stall holds command and memory idle
      repeat (5) begin
         @(negedge clk);
         check("stall_valid", command_valid, 1);
         check_cmd("stall");
         check("stall_req", imem_req, 0);
      end
      command_ready = 1'b1; exp_pc = 3;
      wait_valid("after_stall");
      check_cmd("after_stall");

      // run=0 parks in IDLE after consume
      run = 1'b0;
      @(negedge clk);
      check("idle_req", imem_req, 0);
      check("idle_valid", command_valid, 0);
      @(negedge clk);
      check("idle_req2", imem_req, 0);

      // Redirect without ack: old request drains at old address
      lat = 3; run = 1'b1;
      @(negedge clk);
      check("drop_addr0", imem_addr, 16'h0004);
      @(negedge clk);
      pc_load = 1'b1; pc_target = 16'h0040;
      @(negedge clk);
      pc_load = 1'b0;
      check("drop_req", imem_req, 1);
      check("drop_addr", imem_addr, 16'h0004);
      check("drop_valid", command_valid, 0);
      @(negedge clk);
      check("drop_next_addr", imem_addr, 16'h0040);
      check("drop_next_valid", command_valid, 0);
      exp_pc = 16'h0040;
      wait_valid("drop");
      check_cmd("drop");

      // Redirect in the same cycle as ack discards the word
      lat = 1;
      @(negedge clk);
      check("same_addr0", imem_addr, 16'h0041);
      check("same_req0", imem_req, 1);
      pc_load = 1'b1; pc_target = 16'h0010;
      @(negedge clk);
      pc_load = 1'b0;
      check("same_valid", command_valid, 0);
      check("same_addr", imem_addr, 16'h0010);
      check("same_req", imem_req, 1);
      check("same_cmd_kept", command, mem[8'h40]);
      exp_pc = 16'h0010;
      wait_valid("same");
      command_ready = 1'b0;

      // Random latency, stalls and redirects against the PC-stream model
      for (int i = 0; i < 20; i++) begin
         check_cmd("rnd");
         lat = int'($urandom_range(1, 3));
         stall = int'($urandom_range(0, 3));
         repeat (stall) begin
            @(negedge clk);
            check("rnd_hold_valid", command_valid, 1);
            check_cmd("rnd_hold");
            check("rnd_hold_req", imem_req, 0);
         end
         if ($urandom_range(0, 3) == 0) begin
            tgt = (16'($urandom_range(0, 255)) << 8) | 16'($urandom_range(8'h90, 8'hD0));
            pc_load = 1'b1; pc_target = tgt;
            @(negedge clk);
            pc_load = 1'b0;
            check("rnd_redir_valid", command_valid, 0);
            exp_pc = tgt;
         end else begin
            command_ready = 1'b1;
            @(negedge clk);
            command_ready = 1'b0;
            exp_pc = exp_pc + 1;
         end
         wait_valid("rnd");
      end

      // Asynchronous reset in the middle of a request
      lat = 3; command_ready = 1'b1;
      @(negedge clk);
      command_ready = 1'b0;
      check("mid_req", imem_req, 1);
      #2 rst = 1'b1;
      #1;
      check("arst_req", imem_req, 0);
      check("arst_addr", imem_addr, 0);
      check("arst_cmd", command, 0);
      check("arst_valid", command_valid, 0);
      check("arst_pcout", pc_out, 0);
      check("arst_halted", halted, 0);
      @(negedge clk);
      rst = 1'b0; run = 1'b0;

      // RESET_PC=FFFF: fetch at FFFF then wrap to 0000
      @(negedge clk);
      run2 = 1'b1; ready2 = 1'b1;
      @(negedge clk);
      check("wrap_req0", imem_req2, 1);
      check("wrap_addr0", addr2, 16'hFFFF);
      @(negedge clk);
      check("wrap_valid", command_valid2, 1);
      check("wrap_pcout", pc_out2, 16'hFFFF);
      check("wrap_cmd", command2, 16'h1234);
      @(negedge clk);
      check("wrap_addr1", addr2, 16'h0000);
      run2 = 1'b0;

      // HLT word handling
      lat = 1; pc_load = 1'b1; pc_target = 16'h0080; run = 1'b1;
      @(negedge clk);
      pc_load = 1'b0; exp_pc = 16'h0080;
      wait_valid("hlt");
      check_cmd("hlt");
      command_ready = 1'b1;
      @(negedge clk);
      command_ready = 1'b0;
`ifdef HALT_DETECT_EN
      check("halt_flag", halted, 1);
      check("halt_req", imem_req, 0);
      check("halt_valid", command_valid, 0);
      repeat (3) begin
         @(negedge clk);
         check("halt_hold_req", imem_req, 0);
         check("halt_hold_flag", halted, 1);
      end
      pc_load = 1'b1; pc_target = 16'h0005;
      @(negedge clk);
      pc_load = 1'b0;
      check("unhalt_flag", halted, 0);
      check("unhalt_req", imem_req, 1);
      check("unhalt_addr", imem_addr, 16'h0005);
      exp_pc = 16'h0005;
      wait_valid("unhalt");
      check_cmd("unhalt");
`else
      check("nohalt_flag", halted, 0);
      exp_pc = 16'h0081;
      wait_valid("nohalt");
      check_cmd("nohalt");
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
